fiber_evt_framer: RTL
=====================

// Module: fiber_evt_framer
// PURPOSE
// Downstream of the fiber event handler. Buffers event words arriving on the EVT_FIFO_WR/DATA/END
// interface, wraps each block in a header/trailer frame, and streams it to the Aurora TX
// LocalLink port with valid/ready flow control. Drives the EVT_FIFO_FULL backpressure seen upstream.
// PARAMETERS
// DEPTH_LOG2      9      FIFO depth = 2**DEPTH_LOG2 entries, 33 bits each ({end_flag, data}).
// MAX_FRAME_WORDS 256    Maximum data words per frame; longer blocks are split.
// AFULL_MARGIN    8      EVT_FULL asserts when fill >= 2**DEPTH_LOG2 - AFULL_MARGIN.
// HEADER_TAG      8'hA5  Tag in header word [31:24].
// PORTS
// CLK        in   1   system clock
// RSTb       in   1   asynchronous reset, active-low
// ENABLE     in   1   frame emission enable; FIFO keeps accepting writes when low
// CHANNEL_UP in   1   Aurora channel status
// EVT_WR     in   1   write strobe from event handler
// EVT_DATA   in   32  event word
// EVT_END    in   1   with EVT_WR: end-of-block marker; EVT_DATA ignored, marker stored
// EVT_FULL   out  1   almost-full backpressure to event handler
// TX_DATA    out  32  frame word to Aurora TX
// TX_VALID   out  1   TX_DATA valid
// TX_SOF     out  1   first word of frame (header)
// TX_EOF     out  1   last word of frame
// TX_READY   in   1   Aurora accepts word; a transfer is TX_VALID & TX_READY
// FRAME_CNT  out  16  frames completed, wraps 16'hFFFF -> 0
// OVERRUN    out  1   sticky: write seen while FIFO completely full (word dropped)
// BEHAVIOUR
// Reset: all outputs 0, FSM IDLE, FIFO empty, seq=0, blocks_pending=0, cont=0.
// FIFO: show-ahead, one write per cycle. Write + read in the same cycle leave fill unchanged.
// Write when full: dropped, OVERRUN<=1.
// blocks_pending: +1 on end-marker write, -1 on end-marker pop. Simultaneous +1/-1 -> unchanged.
// FSM IDLE: start when ENABLE & CHANNEL_UP & (blocks_pending>0 | data fill>=MAX_FRAME_WORDS).
//   The next cycle is HEADER.
// HEADER: TX_DATA={HEADER_TAG, seq[7:0], 15'b0, cont}; TX_SOF=1. Go to DATA on transfer.
// DATA: TX_DATA=FIFO head; pop on transfer, count words (wc), accumulate sum.
//   An end-marker head is popped without a transfer (TX_VALID=0 that cycle); cont<=0; go to TRAILER.
//   When wc reaches MAX_FRAME_WORDS before a marker: cont<=1; go to TRAILER.
//   Empty FIFO mid-block: TX_VALID=0, wait.
// TRAILER: TX_DATA={8'h5A, cont, 7'b0, wc[15:0]}; TX_EOF=1 unless CRC_EN.
//   On transfer: seq+1, FRAME_CNT+1, clear wc/sum, go to IDLE (or CHECK).
// TX_VALID/TX_DATA hold stable until TX_READY. Throughput: 1 word/cycle in DATA with READY high.
// CHANNEL_UP low outside IDLE: abort. TX_VALID<=0 next cycle, FIFO flushed, blocks_pending=0,
//   cont=0, FSM IDLE, FRAME_CNT unchanged.
// ENABLE low mid-frame: the current frame completes; no new start.
// Header-to-first-data: 0 bubble cycles when the head is valid.
// CONFIGURATION
// FRAMER_CHECKSUM_EN defined: extra CHECK state after TRAILER.
//   TX_DATA = 32-bit mod-2^32 sum of the frame's data words; TX_EOF on CHECK (not on TRAILER).
// Not defined: no CHECK state; TRAILER carries TX_EOF; frame = wc+2 words.
// TESTING
// T1: 3 words 0x11,0x22,0x33 + END, READY=1 -> header A5000000, 11,22,33, trailer 5A000003;
//   SOF/EOF correct; FRAME_CNT=1.
// T2: 300-word block, MAX=256 -> frame1: 256 data, trailer 5A800100;
//   frame2: header A5010001, 44 data, trailer 5A00002C; FRAME_CNT=2.
// T3: TX_READY toggling 1/0 each cycle over a 10-word block -> no lost or duplicated words;
//   TX_DATA stable while READY=0.
// T4: fill to 504 entries -> EVT_FULL=1; 9 more writes beyond 512 -> OVERRUN=1, stays 1.
// T5: CHANNEL_UP dropped after 5 data words of 20 -> TX_VALID=0 next cycle, FIFO empty;
//   next block starts with a fresh header.
// T6 (FRAMER_CHECKSUM_EN): data 0xFFFFFFFF,0x2 -> CHECK word 0x00000001 with TX_EOF;
//   trailer has TX_EOF=0.

Source files
------------

// File: rtl/fiber_evt_framer.sv
// rtl/fiber_evt_framer.sv - event FIFO plus header/data/trailer framer feeding the Aurora TX LocalLink port.
// Optional FRAMER_CHECKSUM_EN macro adds a CHECK word (mod-2^32 data sum) after the trailer.
module fiber_evt_framer #(
  parameter int         DEPTH_LOG2      = 9,
  parameter int         MAX_FRAME_WORDS = 256,
  parameter int         AFULL_MARGIN    = 8,
  parameter logic [7:0] HEADER_TAG      = 8'hA5
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        ENABLE,
  input  logic        CHANNEL_UP,
  input  logic        EVT_WR,
  input  logic [31:0] EVT_DATA,
  input  logic        EVT_END,
  output logic        EVT_FULL,
  output logic [31:0] TX_DATA,
  output logic        TX_VALID,
  output logic        TX_SOF,
  output logic        TX_EOF,
  input  logic        TX_READY,
  output logic [15:0] FRAME_CNT,
  output logic        OVERRUN
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_MAX   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] FILL_AFULL = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [DEPTH_LOG2:0] FILL_START = (DEPTH_LOG2+1)'(MAX_FRAME_WORDS);
  localparam logic [15:0]         WC_MAX     = 16'(MAX_FRAME_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_TRAILER = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

  logic [32:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_nxt;
  logic [DEPTH_LOG2:0]   fill, blocks_pending;
  logic [2:0]            state;
  logic [7:0]            seq;
  logic                  cont;
  logic [15:0]           wc;
  logic [31:0]           sum;

  logic [32:0] head;
  logic        head_valid, head_end, fifo_full, wr_accept, abort, tx_xfer, pop;

  assign head       = mem[rd_ptr];
  assign head_valid = (fill != '0);
  assign head_end   = head[32];
  assign fifo_full  = (fill == FILL_MAX);
  assign wr_accept  = EVT_WR & ~fifo_full;
  assign wr_ptr_nxt = wr_accept ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
  assign abort      = (state != S_IDLE) & ~CHANNEL_UP;
  assign tx_xfer    = TX_VALID & TX_READY;
  // End markers leave the FIFO without a transfer; data words only on a transfer.
  assign pop        = ~abort & (state == S_DATA) & head_valid & (head_end | TX_READY);
  assign EVT_FULL   = (fill >= FILL_AFULL);

  always_ff @(posedge CLK) begin
    if (wr_accept) mem[wr_ptr] <= {EVT_END, EVT_END ? 32'h0 : EVT_DATA};
  end

  always_comb begin
    TX_VALID = 1'b0;
    TX_DATA  = 32'h0;
    TX_SOF   = 1'b0;
    TX_EOF   = 1'b0;
    case (state)
      S_HEADER: begin
        TX_VALID = 1'b1;
        TX_DATA  = {HEADER_TAG, seq, 15'b0, cont};
        TX_SOF   = 1'b1;
      end
      S_DATA: begin
        TX_VALID = head_valid & ~head_end;
        TX_DATA  = head[31:0];
      end
      S_TRAILER: begin
        TX_VALID = 1'b1;
        TX_DATA  = {8'h5A, cont, 7'b0, wc};
`ifdef FRAMER_CHECKSUM_EN
        TX_EOF   = 1'b0;
`else
        TX_EOF   = 1'b1;
`endif
      end
`ifdef FRAMER_CHECKSUM_EN
      S_CHECK: begin
        TX_VALID = 1'b1;
        TX_DATA  = sum;
        TX_EOF   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill           <= '0;
      blocks_pending <= '0;
      state          <= S_IDLE;
      seq            <= 8'h0;
      cont           <= 1'b0;
      wc             <= 16'h0;
      sum            <= 32'h0;
      FRAME_CNT      <= 16'h0;
      OVERRUN        <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      if (EVT_WR & fifo_full) OVERRUN <= 1'b1;
      if (abort) begin
        // Flush everything, including a write landing in the abort cycle.
        rd_ptr         <= wr_ptr_nxt;
        fill           <= '0;
        blocks_pending <= '0;
        cont           <= 1'b0;
        wc             <= 16'h0;
        sum            <= 32'h0;
        state          <= S_IDLE;
      end else begin
        fill           <= fill + (DEPTH_LOG2+1)'(wr_accept) - (DEPTH_LOG2+1)'(pop);
        blocks_pending <= blocks_pending + (DEPTH_LOG2+1)'(wr_accept & EVT_END)
                          - (DEPTH_LOG2+1)'(pop & head_end);
        if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case (state)
          S_IDLE: begin
            if (ENABLE & CHANNEL_UP & ((blocks_pending != '0) | (fill >= FILL_START)))
              state <= S_HEADER;
          end
          S_HEADER: begin
            if (tx_xfer) state <= S_DATA;
          end
          S_DATA: begin
            if (head_valid) begin
              if (head_end) begin
                cont  <= 1'b0;
                state <= S_TRAILER;
              end else if (TX_READY) begin
                wc  <= wc + 16'd1;
                sum <= sum + head[31:0];
                if ((wc + 16'd1) == WC_MAX) begin
                  cont  <= 1'b1;
                  state <= S_TRAILER;
                end
              end
            end
          end
          S_TRAILER: begin
            if (tx_xfer) begin
              seq       <= seq + 8'd1;
              FRAME_CNT <= FRAME_CNT + 16'd1;
              wc        <= 16'h0;
`ifdef FRAMER_CHECKSUM_EN
              state     <= S_CHECK;
`else
              sum       <= 32'h0;
              state     <= S_IDLE;
`endif
            end
          end
          S_CHECK: begin
            if (tx_xfer) begin
              sum   <= 32'h0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
